// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle for the UART: serial line in, recovered byte and status out.
interface uart_rx_if #(
  parameter int DBIT = 8
) ();
  logic            rx;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            framing_err;

  modport master (
    output rx,
    input  dout,
    input  rx_done_tick,
    input  framing_err
  );

  modport slave (
    input  rx,
    output dout,
    output rx_done_tick,
    output framing_err
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling: synchronises rx, samples each bit at
// mid-point and emits a one-cycle done pulse (FIFO write strobe) per frame.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163,
  parameter int DVSR_W  = 8
) (
  input logic     clk,
  input logic     reset,
  uart_rx_if.slave bus
);

  localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic              r_rx_s1;
  logic              r_rx_s;
  logic [DVSR_W-1:0] r_div;
  logic              w_tick;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_s, w_s_nxt;
  logic [N_W-1:0]    r_n, w_n_nxt;
  logic [DBIT-1:0]   r_b, w_b_nxt;
  logic [DBIT-1:0]   r_dout, w_dout_nxt;
  logic              r_done, w_done_nxt;
  logic              r_ferr, w_ferr_nxt;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_s1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_rx_s1 <= bus.rx;
      r_rx_s  <= r_rx_s1;
    end
  end

  // Free-running oversampling divider; deliberately not re-phased on frame start
  always_ff @(posedge clk) begin
    if (reset || r_div == DVSR_W'(DVSR - 1))
      r_div <= '0;
    else
      r_div <= r_div + DVSR_W'(1);
  end

  assign w_tick = (r_div == DVSR_W'(DVSR - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_n     <= w_n_nxt;
      r_b     <= w_b_nxt;
      r_dout  <= w_dout_nxt;
      r_done  <= w_done_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_b_nxt     = r_b;
    w_dout_nxt  = r_dout;
    w_done_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = START;
          w_s_nxt     = '0;
        end
      end
      START: begin
        if (w_tick) begin
          if (r_s == 4'd7) begin
            // Still low at mid start bit: genuine frame, else a glitch
            if (!r_rx_s) begin
              w_state_nxt = DATA;
              w_s_nxt     = '0;
              w_n_nxt     = '0;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_s_nxt = r_s + 4'd1;
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_s == 4'd15) begin
            w_s_nxt = '0;
            w_b_nxt = {r_rx_s, r_b[DBIT-1:1]};
            if (r_n == N_W'(DBIT - 1))
              w_state_nxt = STOP;
            else
              w_n_nxt = r_n + N_W'(1);
          end else begin
            w_s_nxt = r_s + 4'd1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_s == 4'(SB_TICK - 1)) begin
            // Byte is delivered even on a bad stop bit; the flag lets the consumer decide
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
            w_dout_nxt  = r_b;
            w_ferr_nxt  = ~r_rx_s;
          end else begin
            w_s_nxt = r_s + 4'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.dout         = r_dout;
  assign bus.rx_done_tick = r_done;
  assign bus.framing_err  = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DVSR = 4 (one bit = 64 clk).
module tb_uart_rx;

  localparam int DVSR    = 4;
  localparam int BT      = 16 * DVSR;
  localparam int LAT_MIN = 152 * DVSR;
  localparam int LAT_MAX = 152 * DVSR + DVSR + 3;

  logic clk = 1'b0;
  logic reset;

  uart_rx_if #(.DBIT(8)) bus ();

  uart_rx #(
    .DBIT   (8),
    .SB_TICK(16),
    .DVSR   (DVSR),
    .DVSR_W (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int pulses = 0;
  logic       prev_done = 1'b0;
  logic [7:0] rec_dout [0:63];
  logic       rec_ferr [0:63];
  logic       rec_fnxt [0:63];
  int         rec_cyc  [0:63];

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder: byte, flag, arrival cycle and the flag one clk later
  always @(negedge clk) begin
    if (prev_done && pulses > 0 && pulses <= 64)
      rec_fnxt[pulses-1] <= bus.framing_err;
    prev_done <= bus.rx_done_tick;
    if (bus.rx_done_tick) begin
      if (pulses < 64) begin
        rec_dout[pulses] <= bus.dout;
        rec_ferr[pulses] <= bus.framing_err;
        rec_cyc[pulses]  <= cyc;
      end
      pulses <= pulses + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic send_bits(input logic v, input int n);
    bus.rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bits(1'b0, BT);
    for (int i = 0; i < 8; i++) send_bits(d[i], BT);
    send_bits(stop, BT);
  endtask

  int p0, p1, st, lat, bad;

  initial begin
    bus.rx = 1'b1;
    reset  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: reset state and quiet line
    chk("rst_dout", bus.dout, 8'h00);
    chk("rst_done", bus.rx_done_tick, 1'b0);
    chk("rst_ferr", bus.framing_err, 1'b0);
    send_bits(1'b1, 2000);
    chk("idle_no_pulse", pulses, 0);

    // 2: single 0xA5 frame with latency window
    p0 = pulses;
    st = cyc;
    send_frame(8'hA5, 1'b1);
    send_bits(1'b1, 20);
    chk("a5_count", pulses - p0, 1);
    chk("a5_dout", rec_dout[p0], 8'hA5);
    chk("a5_ferr", rec_ferr[p0], 1'b0);
    lat = rec_cyc[p0] - st;
    chk("a5_lat_ok", (lat >= LAT_MIN && lat <= LAT_MAX), 1'b1);

    // 3: back-to-back 0x00 then 0xFF
    p0 = pulses;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_bits(1'b1, BT);
    chk("b2b_count", pulses - p0, 2);
    chk("b2b_dout0", rec_dout[p0], 8'h00);
    chk("b2b_ferr0", rec_ferr[p0], 1'b0);
    chk("b2b_dout1", rec_dout[p0+1], 8'hFF);
    chk("b2b_ferr1", rec_ferr[p0+1], 1'b0);
    chk("b2b_spacing", rec_cyc[p0+1] - rec_cyc[p0], 10 * BT);

    // 4: short low glitch is rejected, next frame still good
    p0 = pulses;
    send_bits(1'b0, 20);
    send_bits(1'b1, 200);
    chk("glitch_no_pulse", pulses - p0, 0);
    send_frame(8'h3C, 1'b1);
    send_bits(1'b1, 20);
    chk("post_glitch_count", pulses - p0, 1);
    chk("post_glitch_dout", rec_dout[p0], 8'h3C);
    chk("post_glitch_ferr", rec_ferr[p0], 1'b0);

    // 5: bad stop bit; line low through the stop bit can re-arm a junk frame, so only the first pulse is checked
    p0 = pulses;
    send_frame(8'h3C, 1'b0);
    send_bits(1'b1, 800);
    chk("ferr_seen", (pulses > p0), 1'b1);
    chk("ferr_dout", rec_dout[p0], 8'h3C);
    chk("ferr_flag", rec_ferr[p0], 1'b1);
    chk("ferr_next_clk", rec_fnxt[p0], 1'b0);

    // 6: reset during data bit 4 of 0x81
    p0 = pulses;
    send_bits(1'b0, BT);
    send_bits(1'b1, BT);
    for (int i = 1; i < 4; i++) send_bits(1'b0, BT);
    send_bits(1'b0, BT / 2);
    reset = 1'b1;
    send_bits(1'b0, 1);
    reset = 1'b0;
    chk("midrst_dout", bus.dout, 8'h00);
    chk("midrst_done", bus.rx_done_tick, 1'b0);
    chk("midrst_no_pulse", pulses - p0, 0);
    send_bits(1'b0, BT / 2 - 1);
    send_bits(1'b0, BT);
    send_bits(1'b0, BT);
    send_bits(1'b1, BT);
    send_bits(1'b1, BT);
    send_bits(1'b1, 800);
    bad = 0;
    for (int i = p0; i < pulses && i < 64; i++)
      if (rec_dout[i] == 8'h81) bad++;
    chk("midrst_no_81", bad, 0);
    p1 = pulses;
    send_frame(8'h5A, 1'b1);
    send_bits(1'b1, 40);
    chk("after_rst_count", pulses - p1, 1);
    chk("after_rst_dout", rec_dout[p1], 8'h5A);
    chk("after_rst_ferr", rec_ferr[p1], 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver stage of the UART. It feeds the RX FIFO whose empty flag and read data appear at the top level as rx_empty and r_data.
- Synchronises the asynchronous rx line and generates its own 16x oversampling tick from clk.
- Recovers 8N1 frames (LSB first) and presents each byte with a one-cycle rx_done_tick. That pulse serves directly as the FIFO write strobe.

Parameters:
- DBIT, 8, number of data bits per frame.
- SB_TICK, 16, oversampling ticks spent in the stop bit (16 = one stop bit).
- DVSR, 163, clk cycles per oversampling tick (50 MHz / (16 x 19200) ≈ 163). Must be ≥ 2.
- DVSR_W, 8, width of the tick divider counter. Must satisfy 2^DVSR_W > DVSR-1.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- reset, input, 1, synchronous, active-high reset.
- rx, input, 1, asynchronous serial line; idle high.
- dout, output, DBIT, last received byte; holds until the next completed frame.
- rx_done_tick, output, 1, one-cycle pulse when dout is updated (FIFO write enable).
- framing_err, output, 1, valid only while rx_done_tick = 1. It is 1 when the sampled stop bit was 0.

Behaviour:
- Reset (synchronous, reset = 1 at a clk edge) clears all state:
  - sync flops = 1, tick counter = 0, FSM = IDLE, s = 0, n = 0, shift reg = 0.
  - dout = 0, rx_done_tick = 0, framing_err = 0.
  - Reset overrides everything, including mid-frame. A partial frame is discarded and produces no done pulse.
- Synchroniser: two flops, rx -> rx_s1 -> rx_s. The FSM sees only rx_s, which is 2 cycles of latency.
- Tick generator:
  - Free-running counter 0..DVSR-1, wraps to 0.
  - s_tick = 1 for exactly one clk when counter == DVSR-1.
  - Not reset by frame start. Tick phase error is at most 1 tick (1/16 bit).
- Registers: s (4 bits, tick count), n (log2 DBIT bits, bit count), b (DBIT shift reg).
- FSM transitions. All "on tick" actions happen only in cycles with s_tick = 1; otherwise state holds.
  - IDLE: if rx_s == 0, go to START with s = 0. Checked every clk, not only on tick.
  - START: on tick, if s == 7 (mid start bit):
    - rx_s == 0 → DATA, s = 0, n = 0.
    - rx_s == 1 → IDLE (glitch rejected, no pulse).
    - Otherwise s = s + 1.
  - DATA: on tick, if s == 15:
    - s = 0 and b = {rx_s, b[DBIT-1:1]} (LSB first).
    - If n == DBIT-1 → STOP, else n = n + 1.
    - Otherwise s = s + 1.
  - STOP: on tick, if s == SB_TICK-1:
    - Go to IDLE.
    - rx_done_tick = 1 for that single clk.
    - dout = b (registered in the same cycle).
    - framing_err = ~rx_s.
    - Otherwise s = s + 1.
- Outputs are registered. rx_done_tick and framing_err return to 0 on the next clk.
- Latency from rx falling edge to rx_done_tick = (8 + 16·DBIT + SB_TICK)·DVSR clks plus 2..(DVSR+3) clks (sync plus tick phase).
  - DBIT = 8, SB_TICK = 16: 152·DVSR + [2, DVSR+3].
- A framing error still delivers the byte. Integrity is the consumer's decision.
- Back-to-back frames: IDLE re-arms in the cycle after done, so a start bit immediately following the stop bit is accepted.
- rx held low (break condition):
  - One frame with data 0 and framing_err = 1.
  - The FSM then sees rx_s == 0 in IDLE and re-enters START.
  - Further frames of 0x00/framing_err continue until rx returns high.

Test Plan (DVSR = 4, so bit time = 64 clk):
1. Reset held 3 cycles, then released, with rx = 1 → dout = 0x00, rx_done_tick = 0, framing_err = 0. No pulse for 2000 clks.
2. Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop = 1) → exactly one rx_done_tick. It arrives 610–615 clks after the start edge, with dout = 0xA5 and framing_err = 0.
3. Send 0x00 then 0xFF back-to-back with no idle gap → two pulses ~640 clks apart: dout = 0x00 then 0xFF, framing_err = 0 both times.
4. Drive rx low for 20 clks, then high (shorter than 8 ticks) → FSM returns to IDLE and no rx_done_tick. A following 0x3C frame is received correctly.
5. Send 0x3C with stop bit = 0, then rx = 1 → rx_done_tick with dout = 0x3C and framing_err = 1. On the next clk framing_err = 0.
6. Assert reset for 1 clk during data bit 4 of 0x81 → no pulse from that frame and dout = 0x00. A subsequent full 0x5A frame gives dout = 0x5A and framing_err = 0.
